// File: rtl/dlock_ctrl.sv
// dlock_ctrl: attempt-based serial lock controller with timed unlock window and failure lockout
// Ports: clk (state on falling edge), clear (async reset), b_in/b_vld (button bit + strobe),
//        prog_en/prog_code (code reload, honoured only while unlocked),
//        unlock, lockout, fail_cnt, entry_done (registered status outputs)
module dlock_ctrl #(
   parameter int                CODE_W       = 6,
   parameter logic [CODE_W-1:0] DEFAULT_CODE = 6'b101100,
   parameter int                MAX_FAIL     = 3,
   parameter int                UNLOCK_CYC   = 16,
   parameter int                LOCKOUT_CYC  = 64,
   parameter int                GAP_CYC      = 32
) (
   input  logic                          clk,
   input  logic                          clear,
   input  logic                          b_in,
   input  logic                          b_vld,
   input  logic                          prog_en,
   input  logic [CODE_W-1:0]             prog_code,
   output logic                          unlock,
   output logic                          lockout,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
   output logic                          entry_done
);
   localparam int FW   = $clog2(MAX_FAIL + 1);
   localparam int BW   = $clog2(CODE_W + 1);
   localparam int GW   = $clog2(GAP_CYC + 1);
   localparam int TMAX = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
   localparam int TW   = $clog2(TMAX + 1);
   typedef enum logic [1:0] {COLLECT = 2'd0, UNLOCK = 2'd1, LOCKOUT = 2'd2} state_t;
   state_t            state_q, state_d;
   logic [CODE_W-1:0] code_q, code_d, shift_q, shift_d, entry;
   logic [BW-1:0]     bit_q, bit_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [FW-1:0]     fail_q, fail_d, fail_inc;
   logic              unlock_q, unlock_d, lockout_q, lockout_d, done_q, done_d;
   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      shift_d   = shift_q;
      bit_d     = bit_q;
      gap_d     = gap_q;
      tmr_d     = tmr_q;
      fail_d    = fail_q;
      unlock_d  = unlock_q;
      lockout_d = lockout_q;
      done_d    = 1'b0;
      entry     = {shift_q[CODE_W-2:0], b_in};
      fail_inc  = fail_q + FW'(1);
      case (state_q)
         COLLECT: begin
            unlock_d  = 1'b0;
            lockout_d = 1'b0;
            tmr_d     = '0;
            if (b_vld) begin
               gap_d = '0;
               if (bit_q == BW'(CODE_W - 1)) begin
                  done_d  = 1'b1;
                  bit_d   = '0;
                  shift_d = '0;
                  if (entry == code_q) begin
                     state_d  = UNLOCK;
                     unlock_d = 1'b1;
                     fail_d   = '0;
                  end else begin
                     fail_d = fail_inc;
                     if (fail_inc == FW'(MAX_FAIL)) begin
                        state_d   = LOCKOUT;
                        lockout_d = 1'b1;
                     end
                  end
               end else begin
                  shift_d = entry;
                  bit_d   = bit_q + BW'(1);
               end
            end else if (bit_q != '0) begin
               // a stalled partial entry is dropped silently, not counted as a failure
               gap_d = gap_q + GW'(1);
               if (gap_d == GW'(GAP_CYC)) begin
                  gap_d   = '0;
                  bit_d   = '0;
                  shift_d = '0;
               end
            end
         end
         UNLOCK: begin
            if (prog_en || tmr_q == TW'(UNLOCK_CYC - 1)) begin
               state_d  = COLLECT;
               unlock_d = 1'b0;
               tmr_d    = '0;
               code_d   = prog_en ? prog_code : code_q;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         LOCKOUT: begin
            if (tmr_q == TW'(LOCKOUT_CYC - 1)) begin
               state_d   = COLLECT;
               lockout_d = 1'b0;
               fail_d    = '0;
               tmr_d     = '0;
               bit_d     = '0;
               shift_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         default: begin
            state_d   = COLLECT;
            unlock_d  = 1'b0;
            lockout_d = 1'b0;
            fail_d    = '0;
            bit_d     = '0;
            shift_d   = '0;
            gap_d     = '0;
            tmr_d     = '0;
         end
      endcase
   end
   always_ff @(negedge clk or posedge clear) begin
      if (clear) begin
         state_q   <= COLLECT;
         code_q    <= DEFAULT_CODE;
         shift_q   <= '0;
         bit_q     <= '0;
         gap_q     <= '0;
         tmr_q     <= '0;
         fail_q    <= '0;
         unlock_q  <= 1'b0;
         lockout_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         code_q    <= code_d;
         shift_q   <= shift_d;
         bit_q     <= bit_d;
         gap_q     <= gap_d;
         tmr_q     <= tmr_d;
         fail_q    <= fail_d;
         unlock_q  <= unlock_d;
         lockout_q <= lockout_d;
         done_q    <= done_d;
      end
   end
   assign unlock     = unlock_q;
   assign lockout    = lockout_q;
   assign fail_cnt   = fail_q;
   assign entry_done = done_q;
endmodule

// File: tb/tb_dlock_ctrl.sv
// tb_dlock_ctrl: vector table, directed corner sequences and random stimulus against a behavioural lock model
module tb_dlock_ctrl;
   logic       clk = 1'b1, clear = 1'b1, b_in = 1'b0, b_vld = 1'b0, prog_en = 1'b0;
   logic [5:0] prog_code = '0;
   logic       unlock, lockout, entry_done;
   logic [1:0] fail_cnt;
   int         total = 0, bad = 0;
   dlock_ctrl dut (
      .clk(clk), .clear(clear), .b_in(b_in), .b_vld(b_vld), .prog_en(prog_en),
      .prog_code(prog_code), .unlock(unlock), .lockout(lockout),
      .fail_cnt(fail_cnt), .entry_done(entry_done)
   );
   always #5 clk = ~clk;
   int         mode, left, idle;
   logic [5:0] mcode;
   logic [1:0] m_fail;
   logic       m_unlock, m_lockout, m_done;
   bit         ent[$];
   typedef struct { bit v; bit b; bit u; bit l; logic [1:0] f; bit d; } vec_t;
   vec_t tbl[7];
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
      end
   endtask
   task automatic model_reset();
      mode = 0; left = 0; idle = 0; mcode = 6'b101100; m_fail = 0;
      m_unlock = 0; m_lockout = 0; m_done = 0; ent.delete();
   endtask
   task automatic model_step(input bit v, input bit b, input bit pe, input logic [5:0] pc);
      int val;
      m_done = 0;
      if (mode == 0) begin
         if (v) begin
            idle = 0;
            ent.push_back(b);
            if (ent.size() == 6) begin
               val = 0;
               foreach (ent[i]) val = val * 2 + int'(ent[i]);
               ent.delete();
               m_done = 1;
               if (val == int'(mcode)) begin
                  mode = 1; left = 16; m_unlock = 1; m_fail = 0;
               end else begin
                  m_fail = m_fail + 1;
                  if (m_fail == 3) begin mode = 2; left = 64; m_lockout = 1; end
               end
            end
         end else if (ent.size() > 0) begin
            idle++;
            if (idle == 32) begin ent.delete(); idle = 0; end
         end
      end else if (mode == 1) begin
         left--;
         if (pe) mcode = pc;
         if (pe || left == 0) begin mode = 0; m_unlock = 0; end
      end else begin
         left--;
         if (left == 0) begin mode = 0; m_lockout = 0; m_fail = 0; end
      end
   endtask
   task automatic tick(input bit v, input bit b, input bit pe, input logic [5:0] pc);
      b_vld = v; b_in = b; prog_en = pe; prog_code = pc;
      @(negedge clk);
      @(posedge clk);
      model_step(v, b, pe, pc);
      chk("outs", {27'd0, unlock, lockout, fail_cnt, entry_done}, {27'd0, m_unlock, m_lockout, m_fail, m_done});
      chk("excl", {31'd0, unlock & lockout}, 32'd0);
   endtask
   task automatic send(input logic [5:0] v, input int n);
      for (int i = 0; i < n; i++) tick(1'b1, v[5-i], 1'b0, 6'd0);
   endtask
   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 6'd0);
   endtask
   task automatic wait_unlock_end();
      for (int g = 0; g < 40 && unlock; g++) tick(1'b0, 1'b0, 1'b0, 6'd0);
   endtask
   task automatic do_clear();
      clear = 1'b1;
      #1;
      chk("clear_outs", {27'd0, unlock, lockout, fail_cnt, entry_done}, 32'd0);
      model_reset();
      @(negedge clk);
      @(posedge clk);
      clear = 1'b0;
   endtask
   initial begin
      int cnt;
      tbl[0] = '{1, 1, 0, 0, 2'd0, 0};
      tbl[1] = '{1, 0, 0, 0, 2'd0, 0};
      tbl[2] = '{1, 1, 0, 0, 2'd0, 0};
      tbl[3] = '{1, 1, 0, 0, 2'd0, 0};
      tbl[4] = '{1, 0, 0, 0, 2'd0, 0};
      tbl[5] = '{1, 0, 1, 0, 2'd0, 1};
      tbl[6] = '{0, 0, 1, 0, 2'd0, 0};
      model_reset();
      @(negedge clk);
      @(posedge clk);
      chk("reset_outs", {27'd0, unlock, lockout, fail_cnt, entry_done}, 32'd0);
      clear = 1'b0;
      foreach (tbl[i]) begin
         tick(tbl[i].v, tbl[i].b, 1'b0, 6'd0);
         chk($sformatf("vec%0d", i), {27'd0, unlock, lockout, fail_cnt, entry_done},
             {27'd0, tbl[i].u, tbl[i].l, tbl[i].f, tbl[i].d});
      end
      cnt = 2;
      for (int g = 0; g < 40 && unlock; g++) begin
         tick(1'b0, 1'b0, 1'b0, 6'd0);
         if (unlock) cnt++;
      end
      chk("unlock_len", cnt, 16);
      send(6'b101101, 6); chk("fail1", fail_cnt, 1);
      send(6'b101101, 6); chk("fail2", fail_cnt, 2);
      send(6'b101101, 6); chk("lock_on", lockout, 1);
      cnt = 1;
      for (int g = 0; g < 100 && lockout; g++) begin
         tick(1'b1, 1'($urandom), 1'b0, 6'd0);
         if (lockout) cnt++;
      end
      chk("lockout_len", cnt, 64);
      chk("fail_after_lock", fail_cnt, 0);
      send(6'b101000, 3); idle_n(32);
      send(6'b101100, 6); chk("gap32_unlock", unlock, 1);
      wait_unlock_end();
      send(6'b101000, 3); idle_n(31);
      send(6'b100000, 3); chk("gap31_unlock", unlock, 1);
      wait_unlock_end();
      send(6'b101100, 6); idle_n(4);
      tick(1'b0, 1'b0, 1'b1, 6'b010011); chk("prog_drop", unlock, 0);
      send(6'b101100, 6); chk("old_code_fail", fail_cnt, 1);
      send(6'b010011, 6); chk("new_code_unlock", unlock, 1);
      wait_unlock_end();
      send(6'b101100, 6); send(6'b101100, 6); chk("two_fail", fail_cnt, 2);
      send(6'b010011, 6); chk("recover_fail0", fail_cnt, 0);
      wait_unlock_end();
      send(6'b000000, 6); chk("one_more_fail", {30'd0, lockout, fail_cnt == 2'd1}, 32'd1);
      send(6'b101000, 3);
      do_clear();
      send(6'b101100, 6); chk("clear_code_default", unlock, 1);
      tick(1'b0, 1'b0, 1'b1, 6'b111000);
      send(6'b111000, 6); idle_n(3);
      do_clear();
      send(6'b101100, 6); chk("clear_reverts", unlock, 1);
      for (int i = 0; i < 3000; i++) begin
         bit v, b, pe;
         v  = ($urandom_range(0, 99) < 60);
         b  = ($urandom_range(0, 99) < 75 && ent.size() < 6) ? mcode[5 - ent.size()] : 1'($urandom);
         pe = ($urandom_range(0, 99) < 8);
         if ($urandom_range(0, 99) < 4) idle_n(34);
         if ($urandom_range(0, 999) < 5) do_clear();
         else tick(v, b, pe, 6'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
